// File: rtl/lcplc_flag_pkg.sv
// Shared flag definitions for the blocked flag generator and checker.
// A flag_t packs to 4 bits as {last_i, last_b, last_r, last_s}. Bit 0 is last_s.
package lcplc_flag_pkg;

    localparam int FLAG_S    = 0;
    localparam int FLAG_R    = 1;
    localparam int FLAG_B    = 2;
    localparam int FLAG_I    = 3;
    localparam int NUM_FLAGS = 4;

    typedef struct packed {
        logic last_i;
        logic last_b;
        logic last_r;
        logic last_s;
    } flag_t;

    // Build a flag word from the individual flag bits.
    function automatic flag_t make_flags(input logic s, input logic r,
                                         input logic b, input logic i);
        flag_t f;
        f.last_s = s;
        f.last_r = r;
        f.last_b = b;
        f.last_i = i;
        return f;
    endfunction

endpackage

// File: rtl/blocked_position_counter.sv
// Tracks the position inside a blocked image.
// Nesting order, from innermost outward: sample, line, band, block-col, block-row.
// Blocks on the right and bottom edges are truncated to fit the image.
// The expected flags for the current position are produced combinationally.
// The counters advance on each step. A restart returns them to the image origin.
module blocked_position_counter
    import lcplc_flag_pkg::*;
#(
    parameter int MAX_BLOCK_SAMPLE_LOG = 4,
    parameter int MAX_BLOCK_LINE_LOG   = 4,
    parameter int MAX_IMAGE_SAMPLE_LOG = 12,
    parameter int MAX_IMAGE_LINE_LOG   = 12,
    parameter int MAX_IMAGE_BAND_LOG   = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [MAX_BLOCK_SAMPLE_LOG-1:0] config_block_samples,
    input  logic [MAX_BLOCK_LINE_LOG-1:0]   config_block_lines,
    input  logic [MAX_IMAGE_SAMPLE_LOG-1:0] config_image_samples,
    input  logic [MAX_IMAGE_LINE_LOG-1:0]   config_image_lines,
    input  logic [MAX_IMAGE_BAND_LOG-1:0]   config_image_bands,
    input  logic                            step,
    input  logic                            restart,
    output flag_t                           exp_flags
);

    logic [MAX_BLOCK_SAMPLE_LOG-1:0] sample_cnt;
    logic [MAX_BLOCK_LINE_LOG-1:0]   line_cnt;
    logic [MAX_IMAGE_BAND_LOG-1:0]   band_cnt;
    logic [MAX_IMAGE_SAMPLE_LOG-1:0] col_origin;
    logic [MAX_IMAGE_LINE_LOG-1:0]   row_origin;

    logic [MAX_IMAGE_SAMPLE_LOG-1:0] block_samples_ext;
    logic [MAX_IMAGE_LINE_LOG-1:0]   block_lines_ext;
    logic [MAX_IMAGE_SAMPLE_LOG-1:0] col_remaining;
    logic [MAX_IMAGE_LINE_LOG-1:0]   row_remaining;
    logic [MAX_IMAGE_SAMPLE_LOG-1:0] width_m1;
    logic [MAX_IMAGE_LINE_LOG-1:0]   height_m1;
    logic                            last_sample;
    logic                            last_line;
    logic                            last_band;
    logic                            last_col;
    logic                            last_row;

    // Remaining extent from the block origin to the image edge, minus one.
    // The edge block is the one whose remaining extent fits inside a full block.
    assign block_samples_ext = MAX_IMAGE_SAMPLE_LOG'(config_block_samples);
    assign block_lines_ext   = MAX_IMAGE_LINE_LOG'(config_block_lines);
    assign col_remaining     = config_image_samples - col_origin;
    assign row_remaining     = config_image_lines - row_origin;
    assign last_col          = (col_remaining <= block_samples_ext);
    assign last_row          = (row_remaining <= block_lines_ext);
    assign width_m1          = last_col ? col_remaining : block_samples_ext;
    assign height_m1         = last_row ? row_remaining : block_lines_ext;

    assign last_sample = (MAX_IMAGE_SAMPLE_LOG'(sample_cnt) == width_m1);
    assign last_line   = (MAX_IMAGE_LINE_LOG'(line_cnt) == height_m1);
    assign last_band   = (band_cnt == config_image_bands);

    assign exp_flags.last_s = last_sample;
    assign exp_flags.last_r = last_sample && last_line;
    assign exp_flags.last_b = last_sample && last_line && last_band;
    assign exp_flags.last_i = last_sample && last_line && last_band && last_col && last_row;

    // Nested counter update: each level advances when the level below wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt <= '0;
            line_cnt   <= '0;
            band_cnt   <= '0;
            col_origin <= '0;
            row_origin <= '0;
        end else if (restart || (step && exp_flags.last_i)) begin
            sample_cnt <= '0;
            line_cnt   <= '0;
            band_cnt   <= '0;
            col_origin <= '0;
            row_origin <= '0;
        end else if (step) begin
            if (!last_sample) begin
                sample_cnt <= sample_cnt + 1'b1;
            end else begin
                sample_cnt <= '0;
                if (!last_line) begin
                    line_cnt <= line_cnt + 1'b1;
                end else begin
                    line_cnt <= '0;
                    if (!last_band) begin
                        band_cnt <= band_cnt + 1'b1;
                    end else begin
                        band_cnt <= '0;
                        if (!last_col) begin
                            col_origin <= col_origin + block_samples_ext + MAX_IMAGE_SAMPLE_LOG'(1);
                        end else begin
                            // The last block-row never reaches this branch: its
                            // final beat raises exp_i, which restarts the image above.
                            col_origin <= '0;
                            row_origin <= row_origin + block_lines_ext + MAX_IMAGE_LINE_LOG'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/flag_checker_blocked.sv
// Receive-side flag checker for blocked-order AXIS streams.
// It regenerates the expected last_s/r/b/i flags and compares them with the
// received flags. Mismatches set sticky error bits and bump a saturating counter.
// The flags are stripped, and the data is forwarded through one register stage.
module flag_checker_blocked
    import lcplc_flag_pkg::*;
#(
    parameter int DATA_WIDTH           = 16,
    parameter int MAX_BLOCK_SAMPLE_LOG = 4,
    parameter int MAX_BLOCK_LINE_LOG   = 4,
    parameter int MAX_IMAGE_SAMPLE_LOG = 12,
    parameter int MAX_IMAGE_LINE_LOG   = 12,
    parameter int MAX_IMAGE_BAND_LOG   = 12,
    parameter int ERR_CNT_WIDTH        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [MAX_BLOCK_SAMPLE_LOG-1:0] config_block_samples,
    input  logic [MAX_BLOCK_LINE_LOG-1:0]   config_block_lines,
    input  logic [MAX_IMAGE_SAMPLE_LOG-1:0] config_image_samples,
    input  logic [MAX_IMAGE_LINE_LOG-1:0]   config_image_lines,
    input  logic [MAX_IMAGE_BAND_LOG-1:0]   config_image_bands,
    input  logic [DATA_WIDTH-1:0]           input_data,
    input  logic                            input_last_s,
    input  logic                            input_last_r,
    input  logic                            input_last_b,
    input  logic                            input_last_i,
    input  logic                            input_valid,
    output logic                            input_ready,
    output logic [DATA_WIDTH-1:0]           output_data,
    output logic                            output_valid,
    input  logic                            output_ready,
    output logic [NUM_FLAGS-1:0]            flag_error,
    output logic [ERR_CNT_WIDTH-1:0]        error_count,
    output logic                            image_done
);

    flag_t                rx_flags;
    flag_t                exp_flags;
    logic [NUM_FLAGS-1:0] mismatch;
    logic                 accept;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign rx_flags    = make_flags(input_last_s, input_last_r, input_last_b, input_last_i);
    assign input_ready = !output_valid || output_ready;
    assign accept      = input_valid && input_ready;
    assign mismatch    = rx_flags ^ exp_flags;

    // A received last_i forces a resync to image start, whatever was expected.
    blocked_position_counter #(
        .MAX_BLOCK_SAMPLE_LOG (MAX_BLOCK_SAMPLE_LOG),
        .MAX_BLOCK_LINE_LOG   (MAX_BLOCK_LINE_LOG),
        .MAX_IMAGE_SAMPLE_LOG (MAX_IMAGE_SAMPLE_LOG),
        .MAX_IMAGE_LINE_LOG   (MAX_IMAGE_LINE_LOG),
        .MAX_IMAGE_BAND_LOG   (MAX_IMAGE_BAND_LOG)
    ) u_position (
        .clk                  (clk),
        .rst                  (rst),
        .config_block_samples (config_block_samples),
        .config_block_lines   (config_block_lines),
        .config_image_samples (config_image_samples),
        .config_image_lines   (config_image_lines),
        .config_image_bands   (config_image_bands),
        .step                 (accept),
        .restart              (accept && input_last_i),
        .exp_flags            (exp_flags)
    );

    // Output register: load on accept, otherwise hold until downstream takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            output_data  <= '0;
            output_valid <= 1'b0;
        end else if (accept) begin
            output_data  <= input_data;
            output_valid <= 1'b1;
        end else if (output_ready) begin
            output_valid <= 1'b0;
        end
    end

    // Sticky per-flag errors, a saturating mismatch counter and the image_done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_error  <= '0;
            error_count <= '0;
            image_done  <= 1'b0;
        end else begin
            image_done <= accept && input_last_i;
            if (accept) begin
                flag_error <= flag_error | mismatch;
                if (|mismatch) begin
                    error_count <= sat_inc(error_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_flag_checker_blocked.sv
// Bench for flag_checker_blocked.
// The configuration is 3x3 blocks over a 7x7 image with 3 bands.
// The expected flag sequence is tabulated directly from the blocked scan order.
// A cycle model predicts every DUT output, and that prediction is compared on each falling edge.
module tb_flag_checker_blocked;
    import lcplc_flag_pkg::*;

    localparam int N_BEATS = 147;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst_req = 1'b0;
    logic [3:0]  config_block_samples = 4'd2;
    logic [3:0]  config_block_lines   = 4'd2;
    logic [11:0] config_image_samples = 12'd6;
    logic [11:0] config_image_lines   = 12'd6;
    logic [11:0] config_image_bands   = 12'd2;
    logic [15:0] input_data = '0;
    logic        input_last_s = 1'b0;
    logic        input_last_r = 1'b0;
    logic        input_last_b = 1'b0;
    logic        input_last_i = 1'b0;
    logic        input_valid = 1'b0;
    logic        input_ready;
    logic [15:0] output_data;
    logic        output_valid;
    logic        output_ready = 1'b0;
    logic [3:0]  flag_error;
    logic [3:0]  error_count;
    logic        image_done;

    flag_checker_blocked #(.ERR_CNT_WIDTH(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .config_block_samples (config_block_samples),
        .config_block_lines   (config_block_lines),
        .config_image_samples (config_image_samples),
        .config_image_lines   (config_image_lines),
        .config_image_bands   (config_image_bands),
        .input_data           (input_data),
        .input_last_s         (input_last_s),
        .input_last_r         (input_last_r),
        .input_last_b         (input_last_b),
        .input_last_i         (input_last_i),
        .input_valid          (input_valid),
        .input_ready          (input_ready),
        .output_data          (output_data),
        .output_valid         (output_valid),
        .output_ready         (output_ready),
        .flag_error           (flag_error),
        .error_count          (error_count),
        .image_done           (image_done)
    );

    always #5 clk = ~clk;

    // Expected flag sequence of one image and the model's position in it.
    flag_t tbl [N_BEATS];
    int    pos = 0;

    // Model outputs: cur_* is what the DUT must show now, nxt_* is what it must show after the next edge.
    logic [3:0]  cur_err = '0,  nxt_err = '0;
    logic [3:0]  cur_cnt = '0,  nxt_cnt = '0;
    logic        cur_valid = 0, nxt_valid = 0;
    logic        cur_done = 0,  nxt_done = 0;
    logic [15:0] cur_data = '0, nxt_data = '0;

    int checks = 0;
    int passes = 0;
    int done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        cur_err   <= nxt_err;
        cur_cnt   <= nxt_cnt;
        cur_valid <= nxt_valid;
        cur_done  <= nxt_done;
        cur_data  <= nxt_data;
    end

    // Compare process: every DUT output is checked on every falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_output_valid", output_valid, 0);
            chk("rst_output_data", output_data, 0);
            chk("rst_flag_error", flag_error, 0);
            chk("rst_error_count", error_count, 0);
            chk("rst_image_done", image_done, 0);
            chk("rst_input_ready", input_ready, 1);
        end else begin
            chk("output_valid", output_valid, cur_valid);
            chk("output_data", output_data, cur_data);
            chk("flag_error", flag_error, cur_err);
            chk("error_count", error_count, cur_cnt);
            chk("image_done", image_done, cur_done);
            chk("input_ready", input_ready, !cur_valid || output_ready);
            if (image_done) done_seen++;
        end
    end

    // Fill the table by walking the image in blocked order.
    task automatic build_table();
        int idx = 0;
        int bs = 3, bl = 3, iw = 7, ih = 7, nb = 3;
        for (int br = 0; br < ih; br += bl) begin
            int h = (ih - br < bl) ? ih - br : bl;
            for (int bc = 0; bc < iw; bc += bs) begin
                int w = (iw - bc < bs) ? iw - bc : bs;
                for (int band = 0; band < nb; band++)
                    for (int l = 0; l < h; l++)
                        for (int s = 0; s < w; s++) begin
                            flag_t f;
                            f.last_s = (s == w - 1);
                            f.last_r = f.last_s && (l == h - 1);
                            f.last_b = f.last_r && (band == nb - 1);
                            f.last_i = f.last_b && (bc + w == iw) && (br + h == ih);
                            tbl[idx] = f;
                            idx++;
                        end
            end
        end
    endtask

    // Drive one cycle of inputs, then compute the outputs that must follow the next edge.
    task automatic drive(input logic v, input flag_t f, input logic [15:0] d,
                         input logic rdy, output logic acc);
        flag_t      e;
        logic [3:0] mm;
        @(posedge clk); #1;
        rst = rst_req;
        input_valid = v;
        {input_last_i, input_last_b, input_last_r, input_last_s} = f;
        input_data = d;
        output_ready = rdy;
        #1;
        acc = rst && v && input_ready;
        nxt_err = cur_err; nxt_cnt = cur_cnt; nxt_valid = cur_valid;
        nxt_data = cur_data; nxt_done = 1'b0;
        if (!rst) begin
            nxt_err = '0; nxt_cnt = '0; nxt_valid = 1'b0; nxt_data = '0;
            pos = 0;
        end else if (acc) begin
            e = tbl[pos];
            mm = f ^ e;
            nxt_err = cur_err | mm;
            if (mm != 0 && cur_cnt != 4'hF) nxt_cnt = cur_cnt + 4'd1;
            nxt_valid = 1'b1;
            nxt_data = d;
            nxt_done = f.last_i;
            pos = (f.last_i || e.last_i) ? 0 : pos + 1;
        end else if (rdy) begin
            nxt_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, '0, 16'h0, 1'b1, acc);
    endtask

    task automatic reset_pulse();
        rst_req = 1'b0;
        idle(2);
        rst_req = 1'b1;
        idle(2);
    endtask

    // Send nbeats stream beats.
    // mode: 0 clean, 1 drop last_r at beat `special`, 2 force last_i at beat `special`,
    //       3 invert last_s on every beat, 4 random flag corruption on about 1 beat in 16.
    task automatic send_stream(input int nbeats, input int mode, input int special,
                               input int vpct, input int rpct);
        int          k = 0;
        int          budget = 0;
        logic        acc;
        logic [15:0] d = 16'($urandom);
        logic [3:0]  cm = '0;
        if (mode == 4 && $urandom_range(15) == 0) cm = 4'(1 << $urandom_range(3));
        while (k < nbeats) begin
            flag_t f = tbl[k % N_BEATS];
            logic  v = ($urandom_range(99) < vpct);
            logic  r = ($urandom_range(99) < rpct);
            if (mode == 1 && k == special) f.last_r = 1'b0;
            if (mode == 2 && k == special) f.last_i = 1'b1;
            if (mode == 3) f.last_s = ~f.last_s;
            if (mode == 4) f = f ^ cm;
            drive(v, f, d, r, acc);
            if (acc) begin
                k++;
                d = 16'($urandom);
                cm = '0;
                if (mode == 4 && $urandom_range(15) == 0) cm = 4'(1 << $urandom_range(3));
            end
            budget++;
            if (budget > 20000) begin
                chk("stream_timeout", k, nbeats);
                break;
            end
        end
    endtask

    initial begin
        int   s_count = 0;
        int   i_count = 0;
        logic acc;
        build_table();
        for (int i = 0; i < N_BEATS; i++) begin
            s_count += tbl[i].last_s;
            i_count += tbl[i].last_i;
        end
        // Hand-derived values that pin the flag table.
        chk("tbl_beat2", tbl[2], 4'b0001);
        chk("tbl_beat3", tbl[3], 4'b0000);
        chk("tbl_beat8", tbl[8], 4'b0011);
        chk("tbl_beat26", tbl[26], 4'b0111);
        chk("tbl_beat144", tbl[144], 4'b0011);
        chk("tbl_beat146", tbl[146], 4'b1111);
        chk("tbl_s_count", s_count, 63);
        chk("tbl_i_count", i_count, 1);

        // Hold reset, then release it.
        rst_req = 1'b0;
        idle(3);
        rst_req = 1'b1;
        idle(2);

        // Clean image with the source and the drain always enabled.
        send_stream(N_BEATS, 0, 0, 100, 100);
        idle(3);
        chk("clean_flag_error", flag_error, 4'b0000);
        chk("clean_error_count", error_count, 0);
        chk("clean_image_done", done_seen, 1);

        // last_r dropped in the corner block.
        send_stream(N_BEATS, 1, 144, 100, 100);
        idle(3);
        chk("drop_r_flag_error", flag_error, 4'b0010);
        chk("drop_r_error_count", error_count, 1);
        chk("drop_r_image_done", done_seen, 2);
        reset_pulse();

        // Early last_i at beat 50, then a clean image.
        send_stream(51, 2, 50, 100, 100);
        idle(3);
        chk("early_i_flag_error", flag_error, 4'b1000);
        chk("early_i_error_count", error_count, 1);
        chk("early_i_image_done", done_seen, 3);
        send_stream(N_BEATS, 0, 0, 100, 100);
        idle(3);
        chk("after_early_flag_error", flag_error, 4'b1000);
        chk("after_early_error_count", error_count, 1);
        chk("after_early_image_done", done_seen, 4);
        reset_pulse();

        // Random valid and ready with occasional flag corruption. The model checks every cycle.
        send_stream(3 * N_BEATS, 4, 0, 70, 50);
        idle(4);
        reset_pulse();
        send_stream(2 * N_BEATS, 0, 0, 60, 50);
        idle(4);
        chk("random_clean_error_count", error_count, 0);

        // Reset mid-image at beat 70, then a clean image.
        reset_pulse();
        send_stream(70, 0, 0, 100, 50);
        rst_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, tbl[70 + i], 16'hBEEF, 1'b0, acc);
            chk("midrst_output_valid", output_valid, 0);
            chk("midrst_output_data", output_data, 0);
        end
        rst_req = 1'b1;
        idle(2);
        send_stream(N_BEATS, 0, 0, 100, 100);
        idle(3);
        chk("midrst_flag_error", flag_error, 4'b0000);
        chk("midrst_error_count", error_count, 0);

        // Saturation of the 4-bit error counter.
        reset_pulse();
        send_stream(20, 3, 0, 100, 100);
        idle(3);
        chk("sat_error_count", error_count, 15);
        chk("sat_flag_error", flag_error, 4'b0001);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
